// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - PS/2 scan-code constants, command codes and break-code decode.
// KBD_EXT_EN selects whether the E0-prefixed states exist.
package kbd_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_T     = 8'h2C;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [3:0] CMD_NONE  = 4'd0;
  localparam logic [3:0] CMD_F     = 4'd1;
  localparam logic [3:0] CMD_H     = 4'd2;
  localparam logic [3:0] CMD_T     = 4'd3;
  localparam logic [3:0] CMD_UP    = 4'd4;
  localparam logic [3:0] CMD_RIGHT = 4'd5;
  localparam logic [3:0] CMD_LEFT  = 4'd6;
  localparam logic [3:0] CMD_DOWN  = 4'd7;
  localparam logic [3:0] CMD_ESC   = 4'd8;

`ifdef KBD_EXT_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BRK  = 2'd1
  } kbd_state_e;
`endif

  // CMD_NONE marks an unmapped code; it is never pushed.
  function automatic logic [3:0] decode_break(input logic [7:0] code);
    case (code)
      SC_F:     decode_break = CMD_F;
      SC_H:     decode_break = CMD_H;
      SC_T:     decode_break = CMD_T;
      SC_UP:    decode_break = CMD_UP;
      SC_RIGHT: decode_break = CMD_RIGHT;
      SC_LEFT:  decode_break = CMD_LEFT;
      SC_DOWN:  decode_break = CMD_DOWN;
      SC_ESC:   decode_break = CMD_ESC;
      default:  decode_break = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/kbd_cmd_fifo.sv
// rtl/kbd_cmd_fifo.sv - synchronous command FIFO, power-of-two depth.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kbd_cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push && !reset_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kbd_cmd_decoder.sv
// rtl/kbd_cmd_decoder.sv - PS/2 break-code prefix decoder feeding a command FIFO.
// Define KBD_EXT_EN to track the E0 extended prefix.
module kbd_cmd_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] dout,
  input  logic       cmd_rd,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       ovf
);

  kbd_state_e state_q, state_d;
  logic       ovf_q, ovf_d;
  logic [3:0] code_cmd;
  logic       push, pop, fifo_full, fifo_empty;

  assign code_cmd = decode_break(dout);

  // Push is decided combinationally so a command appears one cycle after its tick.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (dout == SC_BRK) state_d = ST_BRK;
`ifdef KBD_EXT_EN
          else if (dout == SC_EXT) state_d = ST_EXT;
`endif
        end
        ST_BRK: begin
          push    = (code_cmd != CMD_NONE);
          state_d = ST_IDLE;
        end
`ifdef KBD_EXT_EN
        ST_EXT: begin
          state_d = (dout == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          push    = (code_cmd != CMD_NONE);
          state_d = ST_IDLE;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pop   = cmd_rd && cmd_valid;
  assign ovf_d = ovf_q | (push && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  kbd_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (4)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .din_i   (code_cmd),
    .pop_i   (pop),
    .dout_o  (cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// tb/tb_kbd_cmd_decoder.sv - directed and random checks of kbd_cmd_decoder against a queue model.
// Follows KBD_EXT_EN the same way as the design.
module tb_kbd_cmd_decoder;

  localparam int DEPTH = 4;
`ifdef KBD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] dout = 8'h00;
  logic       cmd_rd = 1'b0;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       ovf;

  kbd_cmd_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .cmd_rd       (cmd_rd),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  string      phase = "reset";
  logic [3:0] key_map [256];
  logic [7:0] pend [$];
  logic [3:0] mq [$];
  bit         m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, got, exp);
    end
  endtask

  // Prefix bytes seen so far are kept as a list; a byte after a trailing F0 is a break code.
  task automatic model_byte(input logic [7:0] b, output logic [3:0] c);
    c = 4'd0;
    if (pend.size() == 0) begin
      if (b == 8'hF0 || (EXT && b == 8'hE0)) pend.push_back(b);
    end else if (pend[pend.size()-1] == 8'hF0) begin
      c = key_map[b];
      pend.delete();
    end else begin
      if (b == 8'hF0) pend.push_back(b);
      else pend.delete();
    end
  endtask

  task automatic step(input bit tick, input logic [7:0] b, input bit rd, input bit rst = 1'b0);
    logic [3:0] c;
    bit         was_full, do_pop;
    reset = rst; rx_done_tick = tick; dout = b; cmd_rd = rd;
    @(posedge clk);
    if (rst) begin
      pend.delete(); mq.delete(); m_ovf = 1'b0;
    end else begin
      c = 4'd0;
      if (tick) model_byte(b, c);
      was_full = (mq.size() == DEPTH);
      do_pop = rd && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (c != 4'd0) begin
        if (!was_full || do_pop) mq.push_back(c);
        else m_ovf = 1'b1;
      end
    end
    #1;
    chk("cmd_valid", {7'd0, cmd_valid}, {7'd0, mq.size() > 0});
    chk("cmd", {4'd0, cmd}, (mq.size() > 0) ? {4'd0, mq[0]} : 8'd0);
    chk("ovf", {7'd0, ovf}, {7'd0, m_ovf});
    reset = 1'b0; rx_done_tick = 1'b0; cmd_rd = 1'b0;
  endtask

  task automatic brk(input logic [7:0] code, input bit rd = 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, code, rd);
  endtask

  initial begin
    logic [7:0] fill [4];
    logic [7:0] pool [10];
    for (int i = 0; i < 256; i++) key_map[i] = 4'd0;
    key_map[8'h2B] = 4'd1; key_map[8'h33] = 4'd2; key_map[8'h2C] = 4'd3; key_map[8'h75] = 4'd4;
    key_map[8'h74] = 4'd5; key_map[8'h6B] = 4'd6; key_map[8'h72] = 4'd7; key_map[8'h76] = 4'd8;
    fill = '{8'h2B, 8'h33, 8'h2C, 8'h75};
    pool = '{8'hF0, 8'hE0, 8'h2B, 8'h33, 8'h2C, 8'h75, 8'h74, 8'h6B, 8'h72, 8'h76};

    step(1'b1, 8'hF0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_valid", {7'd0, cmd_valid}, 8'd0);
    chk("rst_cmd", {4'd0, cmd}, 8'd0);
    chk("rst_ovf", {7'd0, ovf}, 8'd0);

    phase = "single_break";
    step(1'b1, 8'hF0, 1'b0);
    chk("no_cmd_after_f0", {7'd0, cmd_valid}, 8'd0);
    step(1'b1, 8'h2B, 1'b0);
    chk("valid_lat1", {7'd0, cmd_valid}, 8'd1);
    chk("cmd_f", {4'd0, cmd}, 8'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("popped_valid", {7'd0, cmd_valid}, 8'd0);
    chk("popped_cmd", {4'd0, cmd}, 8'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("pop_empty", {7'd0, cmd_valid}, 8'd0);

    phase = "make_only";
    step(1'b1, 8'h2B, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h76, 1'b0);
    chk("make_no_cmd", {7'd0, cmd_valid}, 8'd0);
    brk(8'h76);
    chk("cmd_esc", {4'd0, cmd}, 8'd8);
    step(1'b0, 8'h00, 1'b1);

    phase = "overflow";
    for (int i = 0; i < 4; i++) brk(fill[i]);
    chk("full_no_ovf", {7'd0, ovf}, 8'd0);
    brk(8'h74);
    chk("ovf_set", {7'd0, ovf}, 8'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", {4'd0, cmd}, i[7:0]);
      step(1'b0, 8'h00, 1'b1);
    end
    chk("drained", {7'd0, cmd_valid}, 8'd0);
    chk("ovf_sticky", {7'd0, ovf}, 8'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", {7'd0, ovf}, 8'd0);

    phase = "full_push_pop";
    for (int i = 0; i < 4; i++) brk(fill[i]);
    brk(8'h76, 1'b1);
    chk("head_adv", {4'd0, cmd}, 8'd2);
    chk("no_ovf", {7'd0, ovf}, 8'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("tail_drained", {7'd0, cmd_valid}, 8'd0);

    phase = "extended";
    step(1'b1, 8'hE0, 1'b0);
    brk(8'h6B);
    chk("ext_left", {4'd0, cmd}, 8'd6);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'h74, 1'b0);
    chk("ext_make", {7'd0, cmd_valid}, 8'd0);
    step(1'b1, 8'hE0, 1'b0);
    brk(8'h75);
    chk("ext_up", {4'd0, cmd}, 8'd4);
    step(1'b0, 8'h00, 1'b1);
    brk(8'hF0);
    brk(8'h33);
    chk("double_f0", {4'd0, cmd}, 8'd2);
    step(1'b0, 8'h00, 1'b1);

    phase = "reset_mid_prefix";
    step(1'b1, 8'hF0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h72, 1'b0);
    chk("abandoned", {7'd0, cmd_valid}, 8'd0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h72, 1'b1, 1'b1);
    step(1'b1, 8'h72, 1'b0);
    chk("tick_in_reset", {7'd0, cmd_valid}, 8'd0);
    brk(8'h72);
    chk("idle_after_rst", {4'd0, cmd}, 8'd7);

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 11) < 10) ? pool[$urandom_range(0, 9)] : 8'($urandom);
      step($urandom_range(0, 1) == 1, b, $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kbd_cmd_decoder.md
KBD_CMD_DECODER -- requirements
Module: kbd_cmd_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port rx_done_tick  input  1  one-cycle strobe from the PS/2 receiver: dout holds a new byte.
REQ-005 SHALL have port dout  input  8  received scan-code byte, sampled only when rx_done_tick=1.
REQ-006 SHALL have port cmd_rd  input  1  consumer pop request; honoured only when cmd_valid=1.
REQ-007 SHALL have port cmd  output  4  command at FIFO head.
REQ-008 SHALL have port cmd_valid  output  1  FIFO not empty.
REQ-009 SHALL have port ovf  output  1  sticky flag: a command was dropped because the FIFO was full.

Function
REQ-010 SHALL run a prefix FSM with states IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen), advancing only on rx_done_tick.
REQ-011 SHALL, in IDLE: F0 -> BRK; E0 -> EXT (when KBD_EXT_EN); any other byte (make code) -> stay IDLE, no command.
REQ-012 SHALL, in BRK or EXT_BRK: on any byte, decode it, push if mapped, return to IDLE.
REQ-013 SHALL, in EXT: F0 -> EXT_BRK; any other byte -> IDLE, no command.
REQ-014 SHALL map break codes: 2B->1 (F), 33->2 (H), 2C->3 (T), 75->4 (UP), 74->5 (RIGHT), 6B->6 (LEFT), 72->7 (DOWN), 76->8 (ESC); unmapped codes are discarded silently; code 0 is never pushed.
REQ-015 SHALL assert cmd_valid the cycle after the rx_done_tick carrying the final code when the FIFO was empty (latency 1).
REQ-016 SHALL pop the head on the cycle cmd_rd=1 and cmd_valid=1; cmd_rd while empty has no effect.
REQ-017 SHALL, when full and a push occurs without a pop, drop the new command and set ovf; ovf stays high until reset.
REQ-018 SHALL, when full and push and pop coincide, accept both; count unchanged, ovf unchanged.
REQ-019 SHALL wrap read/write pointers modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-020 SHALL drive cmd=0 whenever cmd_valid=0.
REQ-021 SHALL ignore a second F0 received while in BRK or EXT_BRK, treating it as an unmapped code and returning to IDLE.

Reset
REQ-022 SHALL, while reset=1, force FSM to IDLE, empty the FIFO, clear ovf; cmd=0, cmd_valid=0.
REQ-023 SHALL abandon a partially received prefix sequence on reset; no command issues from it.
REQ-024 SHALL ignore rx_done_tick and cmd_rd in any cycle where reset=1.

Configuration
REQ-025 SHALL honour macro KBD_EXT_EN: defined -> E0 prefix handled per REQ-011/013, arrows decoded both with and without E0.
REQ-026 SHALL, with KBD_EXT_EN undefined, omit EXT/EXT_BRK states; E0 in IDLE is a make code (REQ-011), so E0 F0 75 still yields UP via BRK.

Structure
REQ-027 SHALL place scan-code constants (F0, E0, eight key codes) and 4-bit command codes in shared package kbd_pkg.
REQ-028 SHALL implement the buffer as sub-module kbd_cmd_fifo (sync FIFO, parameter FIFO_DEPTH, push/pop/full/empty ports).

Verification
REQ-029 SHALL cover: ticks F0,2B with cmd_rd=0 -> cmd_valid=1 with cmd=1 one cycle after the 2B tick; cmd_rd pulse -> cmd_valid=0, cmd=0.
REQ-030 SHALL cover: make-only bytes 2B,33,76 -> cmd_valid stays 0; then F0,76 -> cmd=8.
REQ-031 SHALL cover: sequence F0 2B, F0 33, F0 2C, F0 75, F0 74 with FIFO_DEPTH=4, no pops -> 4 commands 1,2,3,4 read in order, ovf=1, command 5 absent.
REQ-032 SHALL cover: FIFO full, push F0 76 coinciding with cmd_rd -> head advances, 76->8 appended at tail, ovf stays 0.
REQ-033 SHALL cover: KBD_EXT_EN defined, E0 F0 6B -> cmd=6; E0 74 alone -> no command.
REQ-034 SHALL cover: reset asserted after F0 tick, then byte 72 -> no command, FSM IDLE, cmd_valid=0.
